// File: rtl/vajra_axil_sram_slave.sv
// vajra_axil_sram_slave
// AXI4-Lite responder backed by a word-addressed SRAM. Separate write and
// read FSMs, each allowing one outstanding transaction. Addresses outside
// the array return SLVERR and never touch the SRAM.
module vajra_axil_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [31:0]           mem [DEPTH_WORDS];

  w_state_t              w_state, w_state_nxt;
  r_state_t              r_state, r_state_nxt;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic                  wr_in_range, rd_in_range;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  // An address is valid only when every bit above the word index is zero.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (IDX_W + 2)) == '0;
  endfunction

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign b_hs  = S_AXI_BVALID  & S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID  & S_AXI_RREADY;

  // A channel that handshakes in the commit cycle is used straight from the bus.
  assign wr_addr     = aw_held ? awaddr_q : S_AXI_AWADDR;
  assign wr_data     = w_held  ? wdata_q  : S_AXI_WDATA;
  assign wr_strb     = w_held  ? wstrb_q  : S_AXI_WSTRB;
  assign wr_idx      = wr_addr[IDX_W+1:2];
  assign wr_in_range = addr_in_range(wr_addr);

  assign rd_idx      = S_AXI_ARADDR[IDX_W+1:2];
  assign rd_in_range = addr_in_range(S_AXI_ARADDR);

  // Write FSM: READYs depend only on state and held flags; commit once both halves are present.
  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    commit        = 1'b0;
    w_state_nxt   = w_state;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = ~aw_held;
        S_AXI_WREADY  = ~w_held;
        if ((aw_held | S_AXI_AWVALID) & (w_held | S_AXI_WVALID)) begin
          commit      = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write control: state, held flags and the B channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state      <= W_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        S_AXI_BVALID <= 1'b0;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end
    end
  end

  // Capture AW and W payloads as they are accepted.
  always_ff @(posedge clk) begin
    if (aw_hs) awaddr_q <= S_AXI_AWADDR;
    if (w_hs) begin
      wdata_q <= S_AXI_WDATA;
      wstrb_q <= S_AXI_WSTRB;
    end
  end

  // SRAM write port; gated by rst_n so nothing lands while reset is held.
  always_ff @(posedge clk) begin
    if (commit && wr_in_range && rst_n) begin
      mem[wr_idx] <= merge_bytes(mem[wr_idx], wr_data, wr_strb);
    end
  end

  // Read FSM: ARREADY only in idle; response held until RREADY.
  always_comb begin
    S_AXI_ARREADY = 1'b0;
    r_state_nxt   = r_state;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = 1'b1;
        if (S_AXI_ARVALID) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read datapath: the SRAM is sampled before any same-edge write lands, so reads return the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= R_IDLE;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= RESP_OKAY;
      S_AXI_RDATA  <= 32'h0;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        if (rd_in_range) begin
          S_AXI_RDATA <= mem[rd_idx];
          S_AXI_RRESP <= RESP_OKAY;
        end else begin
          S_AXI_RDATA <= 32'h0;
          S_AXI_RRESP <= RESP_SLVERR;
        end
      end else if (r_hs) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vajra_axil_sram_slave.sv
// Testbench for vajra_axil_sram_slave: directed scenarios followed by a
// randomized mix of reads and writes, checked against a word-array model.
module tb_vajra_axil_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [256];

  vajra_axil_sram_slave #(.ADDR_WIDTH(32), .DEPTH_WORDS(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return a[31:10] == 22'h0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    return in_range(a) ? ref_mem[a[9:2]] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_range(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Drive one write; AW and W are offered after awd / wd cycles respectively.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input int hold);
    bit aw_done, w_done;
    int t;
    logic [1:0] eresp;
    aw_done = 0; w_done = 0; t = 0;
    eresp = in_range(a) ? 2'b00 : 2'b10;
    while (!(aw_done && w_done) && t < 40) begin
      @(negedge clk);
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid  = 1'b0;
      if (w_done && !aw_done) check("wready_while_held", {31'h0, wready}, 32'h0);
      if (aw_done && !w_done) check("awready_while_held", {31'h0, awready}, 32'h0);
      check("bvalid_before_commit", {31'h0, bvalid}, 32'h0);
      if (!aw_done && t >= awd) begin awaddr = a; awvalid = 1'b1; end
      if (!w_done && t >= wd) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done  = 1;
      t++;
    end
    check("write_handshake_done", {31'h0, aw_done && w_done}, 32'h1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_latency", {31'h0, bvalid}, 32'h1);
    check("bresp", {30'h0, bresp}, {30'h0, eresp});
    model_write(a, d, s);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bvalid_stall", {31'h0, bvalid}, 32'h1);
      check("bresp_stall", {30'h0, bresp}, {30'h0, eresp});
      check("awready_stall", {31'h0, awready}, 32'h0);
      check("wready_stall", {31'h0, wready}, 32'h0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_cleared", {31'h0, bvalid}, 32'h0);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    logic [31:0] ed;
    logic [1:0]  er;
    ed = exp_read(a);
    er = in_range(a) ? 2'b00 : 2'b10;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    check("arready_idle", {31'h0, arready}, 32'h1);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_latency", {31'h0, rvalid}, 32'h1);
    check("rdata", rdata, ed);
    check("rresp", {30'h0, rresp}, {30'h0, er});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid_stall", {31'h0, rvalid}, 32'h1);
      check("rdata_stall", rdata, ed);
      check("arready_stall", {31'h0, arready}, 32'h0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_cleared", {31'h0, rvalid}, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d, old_w;
    logic [3:0]  s;
    rst_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);
    check("rst_bvalid", {31'h0, bvalid}, 32'h0);
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_bresp", {30'h0, bresp}, 32'h0);
    check("rst_rresp", {30'h0, rresp}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;

    // Fill the whole array so every later read has a defined value.
    for (int i = 0; i < 256; i++) do_write(i * 4, $urandom, 4'hF, 0, 0, 0);

    // Same-cycle AW/W then readback.
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h10, 0);
    check("t1_const", rdata, 32'hDEADBEEF);

    // Partial strobes.
    do_write(32'h10, 32'h11223344, 4'b0101, 0, 0, 0);
    do_read(32'h10, 0);
    check("t2_const", rdata, 32'hDE22BE44);

    // W first, AW three cycles later; then AW first.
    do_write(32'h20, $urandom, 4'hF, 3, 0, 0);
    do_read(32'h20, 0);
    do_write(32'h44, $urandom, 4'b1010, 0, 2, 0);
    do_read(32'h44, 0);

    // Back-pressure on B and R.
    do_write(32'h30, $urandom, 4'hF, 0, 0, 5);
    do_read(32'h30, 5);

    // Out of range on both channels; word 0 untouched.
    do_write(32'h400, 32'h12345678, 4'hF, 0, 0, 0);
    do_read(32'h400, 0);
    do_read(32'h0, 0);

    // Same-edge write and read of one word: read sees the old contents.
    old_w = ref_mem[24];
    d = $urandom;
    @(negedge clk);
    awaddr = 32'h60; wdata = d; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h60; arvalid = 1;
    check("rf_awready", {31'h0, awready}, 32'h1);
    check("rf_arready", {31'h0, arready}, 32'h1);
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("rf_bvalid", {31'h0, bvalid}, 32'h1);
    check("rf_rvalid", {31'h0, rvalid}, 32'h1);
    check("rf_rdata_old", rdata, old_w);
    model_write(32'h60, d, 4'hF);
    bready = 1; rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;
    check("rf_bvalid_clr", {31'h0, bvalid}, 32'h0);
    check("rf_rvalid_clr", {31'h0, rvalid}, 32'h0);
    do_read(32'h60, 0);

    // Reset after AW handshake, before W: the held AW must be forgotten.
    @(negedge clk);
    awaddr = 32'h50; awvalid = 1;
    check("rst_mid_awready", {31'h0, awready}, 32'h1);
    @(negedge clk);
    awvalid = 0;
    rst_n = 0;
    #1;
    check("rst_mid_bvalid", {31'h0, bvalid}, 32'h0);
    @(negedge clk);
    rst_n = 1;
    do_write(32'h50, $urandom, 4'hF, 3, 0, 0);
    do_read(32'h50, 0);

    // Reset while a read response is pending drops RVALID immediately.
    @(negedge clk);
    araddr = 32'h50; arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    check("rst_r_pending", {31'h0, rvalid}, 32'h1);
    rst_n = 0;
    #1;
    check("rst_r_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_r_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1;

    // Random mix.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h400;
      else a = {22'h0, 10'($urandom_range(0, 1023))};
      if ($urandom_range(0, 1) == 0) begin
        s = 4'($urandom);
        do_write(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      end else begin
        do_read(a, $urandom_range(0, 2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
